// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the FSM state encoding, the RV32I funct3 size/sign codes used by
// loads and stores, and the byte-enable width of the data bus.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int BE_W = 4;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Request side: legality/alignment check, byte enables and store-data
// replication from the incoming instruction.
// Response side: byte/half lane selection and sign/zero extension of the
// read data, driven by the captured funct3 and address low bits.
//   req_we_i, req_funct3_i, req_addr_lo_i, req_wdata_i : incoming request
//   req_be_o, req_wdata_o, req_bad_o                   : lanes and illegal/misaligned flag
//   ld_funct3_i, ld_addr_lo_i, ld_rdata_i              : captured load info and bus data
//   ld_data_o                                          : extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [1:0]      req_addr_lo_i,
    input  logic [31:0]     req_wdata_i,
    output logic [BE_W-1:0] req_be_o,
    output logic [31:0]     req_wdata_o,
    output logic            req_bad_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_addr_lo_i,
    input  logic [31:0]     ld_rdata_i,
    output logic [31:0]     ld_data_o
);

    logic       illegal;
    logic       misalign;
    logic [7:0] lane_b;
    logic [15:0] lane_h;

    // Stores only define sizes 0..2 unsigned-free; loads additionally allow
    // the unsigned byte/half forms (4, 5).
    always_comb begin
        if (req_we_i) begin
            illegal = req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3_i[1:0] == 2'b11) | (req_funct3_i == 3'b110);
        end
    end

    always_comb begin
        case (req_funct3_i[1:0])
            2'b00: begin
                misalign    = 1'b0;
                req_be_o    = 4'b0001 << req_addr_lo_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                misalign    = req_addr_lo_i[0];
                req_be_o    = 4'b0011 << {req_addr_lo_i[1], 1'b0};
                req_wdata_o = {2{req_wdata_i[15:0]}};
            end
            default: begin
                misalign    = |req_addr_lo_i;
                req_be_o    = 4'b1111;
                req_wdata_o = req_wdata_i;
            end
        endcase
    end

    assign req_bad_o = illegal | misalign;

    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    lane_b = ld_rdata_i[7:0];
            2'd1:    lane_b = ld_rdata_i[15:8];
            2'd2:    lane_b = ld_rdata_i[23:16];
            default: lane_b = ld_rdata_i[31:24];
        endcase
        lane_h = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

        case (ld_funct3_i)
            F3_LB:   ld_data_o = 32'($signed(lane_b));
            F3_LH:   ld_data_o = 32'($signed(lane_h));
            F3_LBU:  ld_data_o = {24'd0, lane_b};
            F3_LHU:  ld_data_o = {16'd0, lane_h};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit.
// Accepts one load or store from the pipeline in IDLE, issues a single
// word-aligned bus request, waits for the load response (bounded by
// TIMEOUT_CYCLES) and signals completion with a one-cycle o_done.
//   i_clk, i_reset_n                 : clock, async active-low reset
//   i_req_valid/we, i_funct3, i_addr, i_wr_data : instruction from the pipeline
//   o_stall, o_done, o_rd_data       : pipeline control and load result
//   o_misaligned, o_bus_err          : illegal/misaligned flag, load timeout pulse
//   o_bus_*, i_bus_ready             : bus request channel
//   i_bus_rvalid, i_bus_rdata        : bus load response
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_req_valid,
    input  logic                  i_req_we,
    input  logic [2:0]            i_funct3,
    input  logic [DATA_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_misaligned,
    output logic                  o_bus_err,
    output logic                  o_bus_valid,
    input  logic                  i_bus_ready,
    output logic                  o_bus_we,
    output logic [DATA_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    output logic [BE_W-1:0]       o_bus_be,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;

    logic                  capture;
    logic                  req_bad;
    logic                  req_ok;
    logic [BE_W-1:0]       req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] ld_data;

    lsu_align u_align (
        .req_we_i     (i_req_we),
        .req_funct3_i (i_funct3),
        .req_addr_lo_i(i_addr[1:0]),
        .req_wdata_i  (i_wr_data),
        .req_be_o     (req_be),
        .req_wdata_o  (req_wdata),
        .req_bad_o    (req_bad),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_q[1:0]),
        .ld_rdata_i   (i_bus_rdata),
        .ld_data_o    (ld_data)
    );

    assign req_ok = i_req_valid & ~req_bad;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        rd_data_d = rd_data_q;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    capture = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_bus_ready) begin
                    state_d = we_q ? ST_DONE : ST_RESP;
                    cnt_d   = '0;
                end
            end
            ST_RESP: begin
                if (i_bus_rvalid) begin
                    rd_data_d = ld_data;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // This RESP cycle brings the count to TIMEOUT_CYCLES.
                    rd_data_d = '0;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // A still-asserted i_req_valid here is the instruction just
                // completed, so it must not be accepted again.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Request payload is held stable from capture until the next capture.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            we_q     <= i_req_we;
            funct3_q <= i_funct3;
            addr_q   <= i_addr;
            wdata_q  <= req_wdata;
            be_q     <= req_be;
        end
    end

    assign o_stall      = (state_q == ST_REQ) | (state_q == ST_RESP) |
                          ((state_q == ST_IDLE) & req_ok);
    assign o_misaligned = (state_q == ST_IDLE) & i_req_valid & req_bad;
    assign o_done       = (state_q == ST_DONE);
    assign o_bus_err    = err_q;
    assign o_rd_data    = rd_data_q;
    assign o_bus_valid  = (state_q == ST_REQ);
    assign o_bus_we     = we_q;
    assign o_bus_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign o_bus_wdata  = wdata_q;
    assign o_bus_be     = be_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of data and address buses (only 32 supported).
REQ-002 Parameter TIMEOUT_CYCLES, 255, maximum cycles waited for a load response.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low. Ports i_clk (in, 1, rising-edge clock) and i_reset_n (in, 1, async active-low reset).
REQ-004 i_req_valid  in  1  memory-stage instruction is a load/store.
REQ-005 i_req_we  in  1  1 = store, 0 = load.
REQ-006 i_funct3  in  3  RV32I size/sign field (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-007 i_addr  in  32  byte address (ALU result).
REQ-008 i_wr_data  in  32  store data, right-aligned.
REQ-009 o_stall  out  1  freeze all upstream pipeline registers.
REQ-010 o_done  out  1  one-cycle completion pulse.
REQ-011 o_rd_data  out  32  extended load result, valid with o_done.
REQ-012 o_misaligned  out  1  combinational illegal/misaligned flag.
REQ-013 o_bus_err  out  1  one-cycle load-timeout pulse.
REQ-014 o_bus_valid / i_bus_ready  out/in  1/1  request handshake.
REQ-015 o_bus_we, o_bus_addr[31:0] (word-aligned, [1:0]=0), o_bus_wdata[31:0], o_bus_be[3:0]  out  request payload.
REQ-016 i_bus_rvalid  in  1 and i_bus_rdata  in  32  load response.

Function
REQ-017 FSM states IDLE, REQ, RESP, DONE; requests accepted only in IDLE.
REQ-018 IDLE with i_req_valid and legal, aligned access: capture address, data, be and funct3; go to REQ; o_stall=1 in that same cycle.
REQ-019 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; illegal: load funct3 3/6/7, store funct3 3-7. Either case raises o_misaligned (combinational, IDLE only), issues no bus request and does not stall.
REQ-020 REQ: o_bus_valid=1 with stable payload until i_bus_ready; on handshake a store goes to DONE and a load goes to RESP.
REQ-021 RESP: wait for i_bus_rvalid, register the extended data and go to DONE; i_bus_rvalid is ignored in every other state.
REQ-022 Timeout counter starts at 0 on RESP entry and increments each RESP cycle; reaching TIMEOUT_CYCLES without rvalid forces o_rd_data=0, pulses o_bus_err, and goes to DONE.
REQ-023 DONE: o_done=1 and o_stall=0 for exactly one cycle, then IDLE; any i_req_valid in DONE is the same instruction and is ignored.
REQ-024 o_stall = (state is REQ or RESP) or (state is IDLE and a legal aligned request is presented).
REQ-025 Store lanes: SB gives be=0001<<addr[1:0] and wdata={4{byte}}; SH gives be=0011<<(2*addr[1]) and wdata={2{half}}; SW gives be=1111.
REQ-026 Load extraction: LB/LBU use byte lane addr[1:0]; LH/LHU use half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-027 o_rd_data holds its last value except on load completion.
REQ-028 Responses arriving the same cycle as the handshake are not allowed (a response requires at least one RESP cycle).

Reset
REQ-029 Asserting i_reset_n=0 at any time forces IDLE, clears the counter, and drives o_stall, o_done, o_bus_valid, o_bus_err to 0 and o_rd_data to 0 immediately.
REQ-030 An outstanding transaction aborted by reset is dropped, and any late i_bus_rvalid is ignored.

Structure
REQ-031 The shared package lsu_pkg holds the state enum, the funct3 load/store constants and the byte-enable width.
REQ-032 One combinational sub-module, lsu_align, does the byte-lane, byte-enable, replication and extension logic; the FSM, counter and registers stay in load_store_unit.

Verification
REQ-033 SB with addr=0x0000_0013 and data=0x0000_00A5, ready after 2 cycles: be=1000, addr=0x10, wdata=0xA5A5_A5A5, then o_done; o_stall covers 3 cycles.
REQ-034 LB with addr=0x22 and rdata=0x80FF_0000: o_rd_data=0xFFFF_FFFF (lane 2=0xFF); LHU at 0x22 returns 0x0000_80FF.
REQ-035 LW with addr=0x06: o_misaligned=1, no o_bus_valid, o_stall=0.
REQ-036 LW with no rvalid for TIMEOUT_CYCLES: o_bus_err and o_done pulse together, o_rd_data=0, then IDLE.
REQ-037 Reset asserted in RESP, released, then a late rvalid: the FSM stays IDLE, o_done=0, and o_rd_data=0.
REQ-038 Back-to-back LW 0x40 and SW 0x44 with i_req_valid held high through DONE: exactly two bus requests, and the second issues only after the first o_done.
